aes_decrypt: RTL and testbench

- Iterative FIPS-197 AES inverse cipher: takes one 128-bit ciphertext block plus a cipher key and returns the 128-bit plaintext.
- Processes one round per clock and supports AES-128, AES-192 and AES-256 through parameters.
- Standalone datapath block in the crypto processor, paired with the matching encrypt core.
- Simple valid-in / valid-out pulse interface, one block in flight at a time.

---
 rtl/aes_decrypt.sv | 188 ++++++++++++++++++
 tb/tb_aes_decrypt.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt.sv
// Iterative AES inverse cipher (AES-128/192/256), one round per clock.
// Round keys are expanded combinationally from the registered cipher key.
module aes_decrypt #(
  parameter int N  = 128,
  parameter int Nr = 10,
  parameter int Nk = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_vld,
  input  logic [127:0]      in,
  input  logic [32*Nk-1:0]  key,
  output logic [127:0]      out,
  output logic              o_vld
);
  localparam int NW = 4 * (Nr + 1);

  typedef enum logic [1:0] {IDLE, INIT, ROUND, DONE} fsm_e;

  fsm_e              fsm_q, fsm_d;
  logic [127:0]      st_q, st_d;
  logic [32*Nk-1:0]  key_q, key_d;
  logic [3:0]        round_q, round_d;
  logic [127:0]      out_q, out_d;
  logic              o_vld_q, o_vld_d;
  logic [31:0]       w [NW];
  logic [127:0]      rk_cur;
  logic [3:0]        rk_idx;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] v;
    v = gf_inv(b);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = sbox(x[8*b +: 8]);
    return r;
  endfunction

  // Byte k of the block lives at bits [127-8k -: 8]; row r, column c is byte r+4c.
  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic mix);
    logic [127:0] t, m;
    logic [7:0]   a0, a1, a2, a3;
    t = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
    t = t ^ rk;
    m = t;
    if (mix) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[127-32*c -: 8];
        a1 = t[119-32*c -: 8];
        a2 = t[111-32*c -: 8];
        a3 = t[103-32*c -: 8];
        m[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
        m[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
        m[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
        m[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
    end
    return m;
  endfunction

  always_comb begin : key_expand
    logic [31:0] tmp;
    logic [7:0]  rc;
    tmp = '0;
    rc  = 8'h01;
    for (int i = 0; i < NW; i++) begin
      if (i < Nk) begin
        w[i] = key_q[32*(Nk-i)-1 -: 32];
      end else begin
        tmp = w[i-1];
        if (i % Nk == 0) begin
          tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
          rc  = xtime(rc);
        end else if (Nk > 6 && i % Nk == 4) begin
          tmp = sub_word(tmp);
        end
        w[i] = w[i-Nk] ^ tmp;
      end
    end
  end

  always_comb begin
    rk_idx = (fsm_q == INIT) ? 4'(Nr) : round_q;
    rk_cur = '0;
    for (int r = 0; r <= Nr; r++)
      if (rk_idx == 4'(r)) rk_cur = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  end

  always_comb begin
    fsm_d   = fsm_q;
    st_d    = st_q;
    key_d   = key_q;
    round_d = round_q;
    out_d   = out_q;
    o_vld_d = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (i_vld) begin
          st_d  = in;
          key_d = key;
          fsm_d = INIT;
        end
      end
      INIT: begin
        st_d    = st_q ^ rk_cur;
        round_d = 4'(Nr - 1);
        fsm_d   = ROUND;
      end
      ROUND: begin
        st_d = inv_round(st_q, rk_cur, round_q != 4'd0);
        if (round_q == 4'd0) fsm_d = DONE;
        else                 round_d = round_q - 4'd1;
      end
      DONE: begin
        out_d   = st_q;
        o_vld_d = 1'b1;
        fsm_d   = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      fsm_q   <= IDLE;
      st_q    <= '0;
      key_q   <= '0;
      round_q <= '0;
      out_q   <= '0;
      o_vld_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      st_q    <= st_d;
      key_q   <= key_d;
      round_q <= round_d;
      out_q   <= out_d;
      o_vld_q <= o_vld_d;
    end
  end

  assign out   = out_q;
  assign o_vld = o_vld_q;
endmodule

// File: tb/tb_aes_decrypt.sv
// Directed bench for aes_decrypt: three key sizes, reset abort, busy pulse, back-to-back.
// Expected plaintexts and completion cycles go into a scoreboard checked by a negedge monitor.
module tb_aes_decrypt;
  logic         clk;
  logic         rst_n;
  logic         vld [3];
  logic [127:0] in_a [3];
  logic [127:0] out_w [3];
  logic         ov [3];
  logic [127:0] key128;
  logic [191:0] key192;
  logic [255:0] key256;

  typedef struct {
    int           id;
    logic [127:0] data;
    int           due;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] held [3];
  int           cyc = 0;
  int           n_checks = 0;
  int           n_pass = 0;
  int           n_fail = 0;
  logic         mon_en = 1'b0;
  logic         rst_at_edge;
  int           due1;

  aes_decrypt #(.N(128), .Nr(10), .Nk(4)) u_aes128 (
    .i_clk(clk), .i_rst(rst_n), .i_vld(vld[0]), .in(in_a[0]), .key(key128),
    .out(out_w[0]), .o_vld(ov[0]));
  aes_decrypt #(.N(192), .Nr(12), .Nk(6)) u_aes192 (
    .i_clk(clk), .i_rst(rst_n), .i_vld(vld[1]), .in(in_a[1]), .key(key192),
    .out(out_w[1]), .o_vld(ov[1]));
  aes_decrypt #(.N(256), .Nr(14), .Nk(8)) u_aes256 (
    .i_clk(clk), .i_rst(rst_n), .i_vld(vld[2]), .in(in_a[2]), .key(key256),
    .out(out_w[2]), .o_vld(ov[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= !rst_n;
  end

  function automatic int nr_of(input int k);
    return (k == 0) ? 10 : (k == 1) ? 12 : 14;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        if (rst_at_edge) begin
          check($sformatf("reset_out[%0d]", k), out_w[k], '0);
          check($sformatf("reset_ovld[%0d]", k), 128'(ov[k]), '0);
          held[k] = '0;
        end else if (ov[k]) begin
          check($sformatf("ovld_expected[%0d]", k),
                128'(sb.size() > 0 && sb[0].id == k), 128'd1);
          if (sb.size() > 0 && sb[0].id == k) begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("plaintext[%0d]", k), out_w[k], e.data);
            check($sformatf("latency_cycle[%0d]", k), 128'(cyc), 128'(e.due));
            $display("inst %0d: out=%h at cycle %0d (expected %h at %0d)",
                     k, out_w[k], cyc, e.data, e.due);
            held[k] = e.data;
          end
        end else begin
          check($sformatf("out_hold[%0d]", k), out_w[k], held[k]);
        end
      end
      if (rst_at_edge) sb.delete();
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic start(input int k, input logic [127:0] ct, input logic [255:0] kk,
                       input logic [127:0] pt);
    in_a[k] = ct;
    case (k)
      0:       key128 = kk[127:0];
      1:       key192 = kk[191:0];
      default: key256 = kk;
    endcase
    vld[k] = 1'b1;
    sb.push_back('{id: k, data: pt, due: cyc + nr_of(k) + 3});
    tick(1);
    vld[k] = 1'b0;
  endtask

  task automatic wait_drain(input int maxc);
    int i;
    i = 0;
    while (sb.size() != 0 && i < maxc) begin
      tick(1);
      i++;
    end
    check("scoreboard_drained", 128'(sb.size()), '0);
  endtask

  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] K1   = 256'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [255:0] K2   = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] CT3  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] K3   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CTB  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] KB   = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PTB  = 128'h3243f6a8885a308d313198a2e0370734;

  initial begin
    rst_n  = 1'b0;
    key128 = '0;
    key192 = '0;
    key256 = '0;
    for (int k = 0; k < 3; k++) begin
      vld[k]  = 1'b0;
      in_a[k] = '0;
      held[k] = '0;
    end
    tick(1);
    mon_en = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Known-answer vectors for each key size.
    start(1, CT2, K2, PT);
    wait_drain(40);
    tick(4);
    start(0, CT1, K1, PT);
    wait_drain(40);
    tick(4);
    start(2, CT3, K3, PT);
    wait_drain(40);
    tick(4);
    start(0, CTB, KB, PTB);
    wait_drain(40);
    tick(4);

    // Reset mid-run, with i_vld asserted during the reset edge: nothing may complete.
    start(0, CT1, K1, PT);
    tick(4);
    rst_n   = 1'b0;
    vld[0]  = 1'b1;
    in_a[0] = CTB;
    key128  = KB[127:0];
    tick(1);
    rst_n  = 1'b0;
    vld[0] = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(25);
    start(0, CTB, KB, PTB);
    wait_drain(40);
    tick(4);

    // Busy: new data and a start pulse mid-run must be ignored.
    start(0, CT1, K1, PT);
    tick(3);
    in_a[0] = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    key128  = KB[127:0];
    vld[0]  = 1'b1;
    tick(1);
    vld[0] = 1'b0;
    wait_drain(40);
    tick(20);

    // Back-to-back: i_vld held high; second block sampled on re-entry to IDLE.
    in_a[0] = CT1;
    key128  = K1[127:0];
    vld[0]  = 1'b1;
    due1    = cyc + 13;
    sb.push_back('{id: 0, data: PT, due: due1});
    sb.push_back('{id: 0, data: PTB, due: due1 + 13});
    tick(1);
    in_a[0] = CTB;
    key128  = KB[127:0];
    tick(13);
    vld[0] = 1'b0;
    wait_drain(60);
    tick(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
